uart_cmd_rx: RTL

- UART receive front end plus command decoder for the PWM sine generator.
- Drives `phase_inc` (sine frequency tuning word) and `amplitude` (sine scaling), which the sine/PWM stage directly downstream consumes.
- Frame: 8N1, LSB first, idle-high line.
- Commands:
  - 'F' (0x46) + HI byte + LO byte sets `phase_inc`.
  - 'A' (0x41) + one byte sets `amplitude`.

---
 rtl/uart_cmd_rx_if.sv | 22 ++
 rtl/uart_cmd_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - serial input and decoded command outputs of uart_cmd_rx
interface uart_cmd_rx_if;
    logic        uart_rxd;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        frame_err;
    logic        cmd_err;
    logic [15:0] phase_inc;
    logic [7:0]  amplitude;
    logic        cfg_update;

    // Receiver side: takes the serial line, produces bytes and configuration
    modport slave (
        input  uart_rxd,
        output rx_byte, rx_valid, frame_err, cmd_err, phase_inc, amplitude, cfg_update
    );

    modport master (
        output uart_rxd,
        input  rx_byte, rx_valid, frame_err, cmd_err, phase_inc, amplitude, cfg_update
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with 'F'/'A' command decoder driving phase_inc/amplitude
module uart_cmd_rx #(
    parameter int          CLKS_PER_BIT  = 1042,
    parameter int          TIMEOUT_CLKS  = 200000,
    parameter logic [15:0] PHASE_INC_RST = 16'h0100,
    parameter logic [7:0]  AMP_RST       = 8'hFF
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cmd_rx_if.slave   bus
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam int            TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} rx_state_e;
    typedef enum logic [1:0] {P_IDLE, P_FHI, P_FLO, P_AMP} p_state_e;

    logic            rx_meta_q, rxs_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            stop_sample;

    p_state_e        p_state_q, p_state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      hi_q, hi_d;
    logic [15:0]     phase_q, phase_d;
    logic [7:0]      amp_q, amp_d;
    logic            cmd_err_q, cmd_err_d;
    logic            cfg_q, cfg_d;
    logic            tmo_hit, abort;

    // Receiver: state register, synchronizer and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rx_state_q  <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= bus.uart_rxd;
            rxs_q       <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        unique case (rx_state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    rx_state_d = S_START;
                    cnt_d      = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = S_STOP;
                    else                   bit_idx_d  = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    rx_state_d = rxs_q ? S_IDLE : S_WAIT_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (rxs_q) rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stop_sample = (rx_state_q == S_STOP) && (cnt_q == FULL_M1);
        rx_valid_d  = stop_sample && rxs_q;
        frame_err_d = stop_sample && !rxs_q;
        rx_byte_d   = rx_valid_d ? shift_q : rx_byte_q;
    end

    // Parser: state register and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q <= P_IDLE;
            tmo_q     <= '0;
            hi_q      <= '0;
            phase_q   <= PHASE_INC_RST;
            amp_q     <= AMP_RST;
            cmd_err_q <= 1'b0;
            cfg_q     <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            tmo_q     <= tmo_d;
            hi_q      <= hi_d;
            phase_q   <= phase_d;
            amp_q     <= amp_d;
            cmd_err_q <= cmd_err_d;
            cfg_q     <= cfg_d;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout
    assign tmo_hit = (tmo_q == TMO) && !rx_valid_q;
    assign abort   = (p_state_q != P_IDLE) && (frame_err_d || tmo_hit);

    always_comb begin
        p_state_d = p_state_q;
        if (abort) begin
            p_state_d = P_IDLE;
        end else if (rx_valid_q) begin
            unique case (p_state_q)
                P_IDLE: begin
                    if (rx_byte_q == 8'h46)      p_state_d = P_FHI;
                    else if (rx_byte_q == 8'h41) p_state_d = P_AMP;
                end
                P_FHI:   p_state_d = P_FLO;
                default: p_state_d = P_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_err_d = abort || (rx_valid_q && (p_state_q == P_IDLE) &&
                              (rx_byte_q != 8'h46) && (rx_byte_q != 8'h41));
        cfg_d     = rx_valid_q && ((p_state_q == P_FLO) || (p_state_q == P_AMP));
        hi_d      = (rx_valid_q && (p_state_q == P_FHI)) ? rx_byte_q : hi_q;
        phase_d   = (rx_valid_q && (p_state_q == P_FLO)) ? {hi_q, rx_byte_q} : phase_q;
        amp_d     = (rx_valid_q && (p_state_q == P_AMP)) ? rx_byte_q : amp_q;
        if ((p_state_q == P_IDLE) || rx_valid_q) tmo_d = '0;
        else if (tmo_q != TMO)                   tmo_d = tmo_q + 1'b1;
        else                                     tmo_d = tmo_q;
    end

    assign bus.rx_byte    = rx_byte_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.phase_inc  = phase_q;
    assign bus.amplitude  = amp_q;
    assign bus.cfg_update = cfg_q;
endmodule
